// File: rtl/maxpool3x3_stream.sv
// Streaming 3x3 max-pool over a raster-order pixel stream.
// A shift-register line buffer holds two rows plus three pixels; a window fires on
// every accepted pixel that completes an in-frame 3x3 window on the stride grid.
// The result leaves through a two-stage max tree, two cycles after the firing pixel.
// Build option: define MAXPOOL_SIGNED_EN for two's-complement comparisons
// (pre-ReLU data); leave it undefined for unsigned comparisons.
module maxpool3x3_stream #(
  parameter int unsigned WIDTH      = 112,
  parameter int unsigned HEIGHT     = 112,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STRIDE     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int unsigned LbDepth = 2 * WIDTH + 3;
  localparam int unsigned ColW    = $clog2(WIDTH);
  localparam int unsigned RowW    = $clog2(HEIGHT);
  localparam int unsigned PhW     = 2;

  // Stride phase of position 0, chosen so that position 2 lands on phase 0.
  localparam logic [PhW-1:0]  PhInit  = PhW'((STRIDE - (2 % STRIDE)) % STRIDE);
  localparam logic [PhW-1:0]  PhLast  = PhW'(STRIDE - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);

  typedef enum logic [0:0] {StFill, StActive} state_e;

  // Comparison domain is selected at build time; port widths are unaffected.
  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max3(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b,
                                                 input logic [DATA_WIDTH-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  // Position tracking and control
  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [PhW-1:0]  col_ph_q, col_ph_d;
  logic [PhW-1:0]  row_ph_q, row_ph_d;
  logic            fire_q, fire_d;
  logic            frame_done_q, frame_done_d;
  logic            last_px;

  // Line buffer; tap 0 is the newest pixel
  logic [DATA_WIDTH-1:0] lb_q [LbDepth];

  // Max tree stages
  logic [DATA_WIDTH-1:0] row_max [3];
  logic [DATA_WIDTH-1:0] s1_max_q [3];
  logic                  s1_fire_q;
  logic [DATA_WIDTH-1:0] s2_max_q;
  logic                  s2_valid_q;

  assign last_px = (col_q == ColLast) && (row_q == RowLast);

  // Next position, stride phases, FSM and the fire decision for the pixel being accepted
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    col_ph_d     = col_ph_q;
    row_ph_d     = row_ph_q;
    state_d      = state_q;
    fire_d       = 1'b0;
    frame_done_d = 1'b0;

    if (valid_in) begin
      if (col_q == ColLast) begin
        col_d    = '0;
        col_ph_d = PhInit;
        if (row_q == RowLast) begin
          row_d    = '0;
          row_ph_d = PhInit;
        end else begin
          row_d    = row_q + 1'b1;
          row_ph_d = (row_ph_q == PhLast) ? '0 : row_ph_q + 1'b1;
        end
      end else begin
        col_d    = col_q + 1'b1;
        col_ph_d = (col_ph_q == PhLast) ? '0 : col_ph_q + 1'b1;
      end
    end

    unique case (state_q)
      StFill: begin
        // Last pixel of row 1: the next accepted pixel is on row 2.
        if (valid_in && (col_q == ColLast) && (row_q == RowW'(1))) begin
          state_d = StActive;
        end
      end
      StActive: begin
        // Row >= 2 is implied by this state; the column check keeps windows inside a row.
        fire_d = valid_in && (col_q >= ColW'(2)) && (col_ph_q == '0) && (row_ph_q == '0);
        if (valid_in && last_px) begin
          state_d      = StFill;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      col_q        <= '0;
      row_q        <= '0;
      col_ph_q     <= PhInit;
      row_ph_q     <= PhInit;
      fire_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      fire_q       <= fire_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer shifts only on accepted pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LbDepth); i++) begin
        lb_q[i] <= '0;
      end
    end else if (valid_in) begin
      lb_q[0] <= data_in;
      for (int i = 1; i < int'(LbDepth); i++) begin
        lb_q[i] <= lb_q[i-1];
      end
    end
  end

  // Per-row maxima of the window whose bottom-right pixel sits at tap 0
  always_comb begin
    row_max[0] = max3(lb_q[0], lb_q[1], lb_q[2]);
    row_max[1] = max3(lb_q[WIDTH], lb_q[WIDTH+1], lb_q[WIDTH+2]);
    row_max[2] = max3(lb_q[2*WIDTH], lb_q[2*WIDTH+1], lb_q[2*WIDTH+2]);
  end

  // Stage 1: capture row maxima for a firing window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_fire_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        s1_max_q[k] <= '0;
      end
    end else begin
      s1_fire_q <= fire_q;
      if (fire_q) begin
        for (int k = 0; k < 3; k++) begin
          s1_max_q[k] <= row_max[k];
        end
      end
    end
  end

  // Stage 2: final maximum; data is held between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_max_q   <= '0;
    end else begin
      s2_valid_q <= s1_fire_q;
      if (s1_fire_q) begin
        s2_max_q <= max3(s1_max_q[0], s1_max_q[1], s1_max_q[2]);
      end
    end
  end

  assign valid_out  = s2_valid_q;
  assign data_out   = s2_max_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool3x3_stream.sv
// Scoreboard bench for maxpool3x3_stream: a small 8x6 instance for directed frames
// and a default-size instance for one random 112x112 frame.
module tb_maxpool3x3_stream;

  localparam int SW = 8;
  localparam int SH = 6;
  localparam int BW = 112;
  localparam int BH = 112;

`ifdef MAXPOOL_SIGNED_EN
  localparam logic [15:0] Hit = 16'h0001;
`else
  localparam logic [15:0] Hit = 16'hFFFF;
`endif

  typedef struct packed {
    logic [15:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        va, voa, fda;
  logic [15:0] da, doa;
  logic        vb, vob, fdb;
  logic [15:0] db, dob;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   qda[$];
  int   qdb[$];
  int   outs_a = 0, outs_b = 0, fd_a = 0, fd_b = 0;
  logic fda_prev = 1'b0, fdb_prev = 1'b0;
  logic [15:0] pix [BW*BH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool3x3_stream #(.WIDTH(SW), .HEIGHT(SH), .DATA_WIDTH(16), .STRIDE(2)) u_small (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (va),
    .data_in    (da),
    .valid_out  (voa),
    .data_out   (doa),
    .frame_done (fda)
  );

  maxpool3x3_stream u_big (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (vb),
    .data_in    (db),
    .valid_out  (vob),
    .data_out   (dob),
    .frame_done (fdb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the small instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (voa) begin
        outs_a++;
        if (qa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_extra_output: got %0h, expected no output (cycle %0d)", doa, cyc);
        end else begin
          e = qa.pop_front();
          check("a_data", doa, e.val);
          check("a_latency", cyc, e.due);
        end
      end
      if (fda) begin
        fd_a++;
        check("a_fd_not_double", fda_prev, 0);
        if (qda.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_extra_frame_done: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          check("a_fd_cycle", cyc, qda.pop_front());
        end
      end
    end
    fda_prev = fda;
  end

  // Monitor for the default-size instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vob) begin
        outs_b++;
        if (qb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_extra_output: got %0h, expected no output (cycle %0d)", dob, cyc);
        end else begin
          e = qb.pop_front();
          check("b_data", dob, e.val);
          check("b_latency", cyc, e.due);
        end
      end
      if (fdb) begin
        fd_b++;
        check("b_fd_not_double", fdb_prev, 0);
        if (qdb.size() > 0) check("b_fd_cycle", cyc, qdb.pop_front());
      end
    end
    fdb_prev = fdb;
  end

  // Drive one frame into the small instance; called at a falling edge.
  // mode 0: ramp r*8+c, 1: all 5, 2: 0xFFFF with 0x8000 at (3,3), 3: 0xFFFF with 0x0001 at (3,3)
  task automatic frame_a(input int mode, input bit toggle, input int stop_at);
    int ramp_exp [6] = '{18, 20, 22, 34, 36, 38};
    int k = 0;
    logic [15:0] v, ev;
    bit fire;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        if (r * SW + c == stop_at) return;
        case (mode)
          0:       v = 16'(r * SW + c);
          1:       v = 16'h0005;
          2:       v = (r == 3 && c == 3) ? 16'h8000 : 16'hFFFF;
          default: v = (r == 3 && c == 3) ? 16'h0001 : 16'hFFFF;
        endcase
        fire = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
        va = 1'b1;
        da = v;
        if (fire) begin
          case (mode)
            0:       ev = 16'(ramp_exp[k]);
            1:       ev = 16'h0005;
            2:       ev = 16'hFFFF;
            default: ev = (k == 4) ? Hit : 16'hFFFF;
          endcase
          qa.push_back('{val: ev, due: cyc + 3});
          k++;
        end
        if (r == SH - 1 && c == SW - 1) qda.push_back(cyc + 1);
        @(negedge clk);
        if (toggle) begin
          va = 1'b0;
          da = 16'hDEAD;
          @(negedge clk);
        end
      end
    end
    va = 1'b0;
    da = 16'hDEAD;
  endtask

  task automatic idle(input int n);
    va = 1'b0;
    vb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Ends a directed test: outputs and frame_done pulses seen since the snapshot
  task automatic end_test(input string name, input int o0, input int exp_outs,
                          input int f0, input int exp_fd);
    idle(6);
    check({name, "_out_count"}, outs_a - o0, exp_outs);
    check({name, "_fd_count"}, fd_a - f0, exp_fd);
    check({name, "_pending"}, qa.size(), 0);
  endtask

  initial begin
    int o0, f0, ob0, fb0;
    logic [15:0] m;
    va = 1'b0;
    da = '0;
    vb = 1'b0;
    db = '0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", voa, 0);
    check("rst_data_out", doa, 0);
    check("rst_frame_done", fda, 0);
    rst = 1'b0;
    idle(2);
    check("post_rst_valid_out", voa, 0);

    // Ramp frame, continuous valid
    o0 = outs_a; f0 = fd_a;
    frame_a(0, 1'b0, -1);
    end_test("ramp", o0, 6, f0, 1);

    // Ramp frame, valid toggling
    o0 = outs_a; f0 = fd_a;
    frame_a(0, 1'b1, -1);
    end_test("ramp_gap", o0, 6, f0, 1);

    // Back-to-back frames: ramp then constant 5
    o0 = outs_a; f0 = fd_a;
    frame_a(0, 1'b0, -1);
    frame_a(1, 1'b0, -1);
    end_test("b2b", o0, 12, f0, 2);

    // Signed-sensitive frames
    o0 = outs_a; f0 = fd_a;
    frame_a(2, 1'b0, -1);
    end_test("neg_min", o0, 6, f0, 1);
    o0 = outs_a; f0 = fd_a;
    frame_a(3, 1'b0, -1);
    end_test("pos_one", o0, 6, f0, 1);

    // Reset asserted while pixel (3,5) is presented
    o0 = outs_a;
    frame_a(0, 1'b0, 29);
    idle(1);
    check("hold_before_rst", doa, 16'd22);
    check("rst_mid_outs_so_far", outs_a - o0, 3);
    va = 1'b1;
    da = 16'd29;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid_out", voa, 0);
    check("async_rst_data_out", doa, 0);
    check("async_rst_frame_done", fda, 0);
    va = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qda.delete();
    o0 = outs_a; f0 = fd_a;
    frame_a(0, 1'b0, -1);
    end_test("after_rst", o0, 6, f0, 1);

    // Default-size instance, one random frame against a 3x3 max model
    for (int i = 0; i < BW * BH; i++) pix[i] = 16'($urandom_range(0, 65535));
    ob0 = outs_b; fb0 = fd_b;
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW; c++) begin
        vb = 1'b1;
        db = pix[r*BW+c];
        if (r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0) begin
          m = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              if (pix[(r-dr)*BW+(c-dc)] > m) m = pix[(r-dr)*BW+(c-dc)];
          qb.push_back('{val: m, due: cyc + 3});
        end
        if (r == BH - 1 && c == BW - 1) qdb.push_back(cyc + 1);
        @(negedge clk);
      end
    end
    idle(6);
    check("big_out_count", outs_b - ob0, 3025);
    check("big_fd_count", fd_b - fb0, 1);
    check("big_pending", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
